dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the ARMV4 core (load/store path), port 1 is a loader/debug master (program/data preload, memory dump).
- The arbiter is inserted between the requesters and data_memory. Its registered owner FSM grants one port at a time.
- Round-robin tie-break and a bounded burst length prevent starvation.
- The core uses ~r0_gnt as its stall qualifier.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core (port 0) and loader/debug (port 1).
// Registered owner FSM with round-robin tie-break and a bounded burst so neither port starves.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_adr,
  input  logic [DW-1:0] r0_wd,
  output logic          r0_gnt,
  output logic [DW-1:0] r0_rd,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_adr,
  input  logic [DW-1:0] r1_wd,
  output logic          r1_gnt,
  output logic [DW-1:0] r1_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int            CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        r_state;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_gnt0;
  logic          r_gnt1;

  logic [CW-1:0] w_cnt_n;
  logic          w_acc0;
  logic          w_acc1;

  // Burst counter saturates so a lone requester can stream forever.
  assign w_cnt_n = (r_cnt == CMAX) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (r0_req && (!r1_req || r_last)) begin
            r_state <= OWN0;
            r_gnt0  <= 1'b1;
            r_gnt1  <= 1'b0;
          end else if (r1_req) begin
            r_state <= OWN1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b1;
          end
        end
        OWN0: begin
          if (r0_req) begin
            r_last <= 1'b0;
            if (w_cnt_n == CMAX && r1_req) begin
              r_state <= OWN1;
              r_gnt0  <= 1'b0;
              r_gnt1  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_n;
            end
          end else begin
            r_cnt  <= '0;
            r_gnt0 <= 1'b0;
            if (r1_req) begin
              r_state <= OWN1;
              r_gnt1  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_gnt1  <= 1'b0;
            end
          end
        end
        OWN1: begin
          if (r1_req) begin
            r_last <= 1'b1;
            if (w_cnt_n == CMAX && r0_req) begin
              r_state <= OWN0;
              r_gnt0  <= 1'b1;
              r_gnt1  <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_n;
            end
          end else begin
            r_cnt  <= '0;
            r_gnt1 <= 1'b0;
            if (r0_req) begin
              r_state <= OWN0;
              r_gnt0  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_gnt0  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
      endcase
    end
  end

  assign r0_gnt = r_gnt0;
  assign r1_gnt = r_gnt1;
  assign w_acc0 = r_gnt0 & r0_req;
  assign w_acc1 = r_gnt1 & r1_req;

  // Memory bus is driven straight from the owning port so reads see zero added latency.
  always_comb begin
    mem_we  = 1'b0;
    mem_adr = '0;
    mem_wd  = '0;
    if (w_acc0) begin
      mem_we  = r0_we;
      mem_adr = r0_adr;
      mem_wd  = r0_wd;
    end else if (w_acc1) begin
      mem_we  = r1_we;
      mem_adr = r1_adr;
      mem_wd  = r1_wd;
    end
  end

  assign r0_rd = r_gnt0 ? mem_rd : '0;
  assign r1_rd = r_gnt1 ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: MAX_BURST=4 and MAX_BURST=1 instances share one memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_adr, r0_wd, r1_adr, r1_wd;

  logic        r0_gnt, r1_gnt, mem_we;
  logic [31:0] r0_rd, r1_rd, mem_adr, mem_wd, mem_rd;
  logic        b_r0_gnt, b_r1_gnt, b_mem_we;
  logic [31:0] b_r0_rd, b_r1_rd, b_mem_adr, b_mem_wd, b_mem_rd;

  logic [31:0] mem [0:63];

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        q0, q1, e0, e1, crd;
    logic [31:0] a0, a1, madr, rd0, rd1;
  } ent_t;
  ent_t sbq[$];

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_adr(r0_adr), .r0_wd(r0_wd), .r0_gnt(r0_gnt), .r0_rd(r0_rd),
    .r1_req(r1_req), .r1_we(r1_we), .r1_adr(r1_adr), .r1_wd(r1_wd), .r1_gnt(r1_gnt), .r1_rd(r1_rd),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_adr(r0_adr), .r0_wd(r0_wd), .r0_gnt(b_r0_gnt), .r0_rd(b_r0_rd),
    .r1_req(r1_req), .r1_we(r1_we), .r1_adr(r1_adr), .r1_wd(r1_wd), .r1_gnt(b_r1_gnt), .r1_rd(b_r1_rd),
    .mem_we(b_mem_we), .mem_adr(b_mem_adr), .mem_wd(b_mem_wd), .mem_rd(b_mem_rd)
  );

  // Memory is reinitialised with a known pattern while reset is held; only the MAX_BURST=4 instance writes.
  assign mem_rd   = mem[mem_adr[7:2]];
  assign b_mem_rd = mem[b_mem_adr[7:2]];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
    end else if (mem_we) begin
      mem[mem_adr[7:2]] <= mem_wd;
    end
  end

  function automatic logic [31:0] mval(input logic [31:0] a);
    return 32'hC0DE_0000 + {26'd0, a[7:2]};
  endfunction

  function automatic void push(input logic q0, input logic q1, input logic e0, input logic e1,
                               input logic [31:0] a0, input logic [31:0] a1);
    ent_t e;
    e.q0   = q0;
    e.q1   = q1;
    e.e0   = e0;
    e.e1   = e1;
    e.a0   = a0;
    e.a1   = a1;
    e.madr = (e0 && q0) ? a0 : ((e1 && q1) ? a1 : 32'h0);
    e.crd  = !((e0 && !q0) || (e1 && !q1));
    e.rd0  = e0 ? mval(e.madr) : 32'h0;
    e.rd1  = e1 ? mval(e.madr) : 32'h0;
    sbq.push_back(e);
  endfunction

  task automatic do_reset();
    reset  = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_adr = '0; r0_wd = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_adr = '0; r1_wd = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_adr = '0; r0_wd = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_adr = '0; r1_wd = '0;
    #2;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({r0_gnt, r1_gnt, mem_we, mem_adr, mem_wd} !== 67'h0) begin
      n_err++;
      $display("FAIL reset_async got gnt=%b%b we=%b adr=%h wd=%h want all 0", r0_gnt, r1_gnt, mem_we, mem_adr, mem_wd);
    end
    n_chk++;
    if ({b_r0_gnt, b_r1_gnt, b_mem_we} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_async_b1 got %b%b%b want 000", b_r0_gnt, b_r1_gnt, b_mem_we);
    end
    r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b1; r0_adr = 32'h44;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_chk++;
    if ({r0_gnt, r1_gnt, mem_we, mem_adr} !== 35'h0) begin
      n_err++;
      $display("FAIL reset_held got gnt=%b%b we=%b adr=%h want all 0", r0_gnt, r1_gnt, mem_we, mem_adr);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    r0_req = 1'b1; r0_we = 1'b1; r0_adr = 32'h10; r0_wd = 32'hAA;
    #2;
    n_chk++;
    if ({r0_gnt, mem_we} !== 2'b00) begin
      n_err++;
      $display("FAIL wr_latency got gnt=%b we=%b want 0 0", r0_gnt, mem_we);
    end
    @(posedge clk); #1; #2;
    n_chk++;
    if ({r0_gnt, mem_we, mem_adr, mem_wd} !== {1'b1, 1'b1, 32'h10, 32'hAA}) begin
      n_err++;
      $display("FAIL wr_access got gnt=%b we=%b adr=%h wd=%h want 1 1 10 aa", r0_gnt, mem_we, mem_adr, mem_wd);
    end
    @(posedge clk); #1;
    r0_we = 1'b0;
    #2;
    n_chk++;
    if ({r0_gnt, mem_we, r0_rd} !== {1'b1, 1'b0, 32'hAA}) begin
      n_err++;
      $display("FAIL rd_back got gnt=%b we=%b rd=%h want 1 0 aa", r0_gnt, mem_we, r0_rd);
    end
    @(posedge clk); #1;
    r0_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_tie_handover();
    int k = 0;
    do_reset();
    r0_we = 1'b0; r1_we = 1'b0;
    push(1, 1, 0, 0, 32'h20, 32'h30);
    push(1, 1, 1, 0, 32'h20, 32'h30);
    push(0, 1, 1, 0, 32'h20, 32'h30);
    push(0, 1, 0, 1, 32'h20, 32'h30);
    push(0, 0, 0, 1, 32'h20, 32'h30);
    push(0, 0, 0, 0, 32'h20, 32'h30);
    while (sbq.size() > 0) begin
      ent_t e = sbq.pop_front();
      r0_req = e.q0; r1_req = e.q1; r0_adr = e.a0; r1_adr = e.a1;
      #2;
      n_chk++;
      if ({r0_gnt, r1_gnt, mem_adr} !== {e.e0, e.e1, e.madr}) begin
        n_err++;
        $display("FAIL tie cyc%0d gnt/adr got %b%b/%h want %b%b/%h", k, r0_gnt, r1_gnt, mem_adr, e.e0, e.e1, e.madr);
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_burst4();
    int k = 0;
    do_reset();
    r0_we = 1'b0; r1_we = 1'b0;
    push(1, 1, 0, 0, 32'h20, 32'h30);
    for (int t = 0; t < 3; t++)
      for (int j = 0; j < 4; j++) push(1, 1, t != 1, t == 1, 32'h20, 32'h30);
    push(0, 0, 0, 1, 32'h20, 32'h30);
    push(0, 0, 0, 0, 32'h20, 32'h30);
    while (sbq.size() > 0) begin
      ent_t e = sbq.pop_front();
      r0_req = e.q0; r1_req = e.q1; r0_adr = e.a0; r1_adr = e.a1;
      #2;
      n_chk++;
      if ({r0_gnt, r1_gnt, mem_adr} !== {e.e0, e.e1, e.madr}) begin
        n_err++;
        $display("FAIL burst4 cyc%0d gnt/adr got %b%b/%h want %b%b/%h", k, r0_gnt, r1_gnt, mem_adr, e.e0, e.e1, e.madr);
      end
      if (e.crd) begin
        n_chk++;
        if ({r0_rd, r1_rd} !== {e.rd0, e.rd1}) begin
          n_err++;
          $display("FAIL burst4_rd cyc%0d got %h/%h want %h/%h", k, r0_rd, r1_rd, e.rd0, e.rd1);
        end
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_stream();
    int k = 0;
    do_reset();
    r0_we = 1'b0; r1_we = 1'b0;
    push(0, 1, 0, 0, 32'h8, 32'h0);
    for (int i = 0; i < 10; i++) push(0, 1, 0, 1, 32'h8, 32'(i * 4));
    push(1, 1, 0, 1, 32'h8, 32'h0);
    push(1, 1, 1, 0, 32'h8, 32'h0);
    push(0, 0, 1, 0, 32'h8, 32'h0);
    push(0, 0, 0, 0, 32'h8, 32'h0);
    while (sbq.size() > 0) begin
      ent_t e = sbq.pop_front();
      r0_req = e.q0; r1_req = e.q1; r0_adr = e.a0; r1_adr = e.a1;
      #2;
      n_chk++;
      if ({r0_gnt, r1_gnt, mem_adr} !== {e.e0, e.e1, e.madr}) begin
        n_err++;
        $display("FAIL stream cyc%0d gnt/adr got %b%b/%h want %b%b/%h", k, r0_gnt, r1_gnt, mem_adr, e.e0, e.e1, e.madr);
      end
      if (e.crd) begin
        n_chk++;
        if ({r0_rd, r1_rd} !== {e.rd0, e.rd1}) begin
          n_err++;
          $display("FAIL stream_rd cyc%0d got %h/%h want %h/%h", k, r0_rd, r1_rd, e.rd0, e.rd1);
        end
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    r1_req = 1'b1; r1_we = 1'b1; r1_adr = 32'h30; r1_wd = 32'h55;
    @(posedge clk); #1; #1;
    n_chk++;
    if ({r1_gnt, mem_we, mem_adr} !== {1'b1, 1'b1, 32'h30}) begin
      n_err++;
      $display("FAIL mid_pre got gnt=%b we=%b adr=%h want 1 1 30", r1_gnt, mem_we, mem_adr);
    end
    #1;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({r1_gnt, mem_we, mem_adr} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL mid_async got gnt=%b we=%b adr=%h want 0 0 0", r1_gnt, mem_we, mem_adr);
    end
    @(posedge clk); #1;
    r1_req = 1'b0; r1_we = 1'b0;
    r0_req = 1'b1; r0_we = 1'b0; r0_adr = 32'h8;
    reset = 1'b1;
    #2;
    n_chk++;
    if ({r0_gnt, r1_gnt} !== 2'b00) begin
      n_err++;
      $display("FAIL mid_idle got gnt=%b%b want 00", r0_gnt, r1_gnt);
    end
    @(posedge clk); #1; #2;
    n_chk++;
    if ({r0_gnt, r1_gnt, r0_rd} !== {2'b10, mval(32'h8)}) begin
      n_err++;
      $display("FAIL mid_regrant got gnt=%b%b rd=%h want 10 %h", r0_gnt, r1_gnt, r0_rd, mval(32'h8));
    end
    r0_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_burst1();
    int k = 0;
    do_reset();
    r0_we = 1'b0; r1_we = 1'b0;
    push(1, 1, 0, 0, 32'h20, 32'h30);
    for (int j = 0; j < 6; j++) push(1, 1, j % 2 == 0, j % 2 == 1, 32'h20, 32'h30);
    push(0, 0, 1, 0, 32'h20, 32'h30);
    push(0, 0, 0, 0, 32'h20, 32'h30);
    while (sbq.size() > 0) begin
      ent_t e = sbq.pop_front();
      r0_req = e.q0; r1_req = e.q1; r0_adr = e.a0; r1_adr = e.a1;
      #2;
      n_chk++;
      if ({b_r0_gnt, b_r1_gnt, b_mem_adr} !== {e.e0, e.e1, e.madr}) begin
        n_err++;
        $display("FAIL burst1 cyc%0d gnt/adr got %b%b/%h want %b%b/%h", k, b_r0_gnt, b_r1_gnt, b_mem_adr, e.e0, e.e1, e.madr);
      end
      if (e.crd) begin
        n_chk++;
        if ({b_r0_rd, b_r1_rd} !== {e.rd0, e.rd1}) begin
          n_err++;
          $display("FAIL burst1_rd cyc%0d got %h/%h want %h/%h", k, b_r0_rd, b_r1_rd, e.rd0, e.rd1);
        end
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie_handover();
    test_burst4();
    test_stream();
    test_reset_mid();
    test_burst1();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
